// File: rtl/bus_master_pkg.sv
// rtl/bus_master_pkg.sv - shared state encoding and function code for bus_master
package bus_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_ADDR,
    S_STROBE,
    S_LATCH,
    S_RELEASE,
    S_FINISH
  } state_e;

  // Every cycle this master runs is a supervisor data access.
  localparam logic [2:0] FC_SUP_DATA = 3'b101;

endpackage

// File: rtl/bus_master_sync2.sv
// rtl/bus_master_sync2.sv - two-flop synchronizer for one asynchronous bus input
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bus_master.sv
// rtl/bus_master.sv - single-transfer bus master with arbitration handshake
// Optional STROBE timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        MCLK_IN,
  input  logic        RESET_IN,
  input  logic        REQ_IN,
  input  logic        REQ_WR_IN,
  input  logic [22:0] REQ_ADDR_IN,
  input  logic [15:0] REQ_DATA_IN,
  input  logic        REQ_UDS_IN,
  input  logic        REQ_LDS_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [15:0] RDATA,
  input  logic        BG_IN,
  input  logic        AS_IN,
  input  logic        DTACK_IN,
  input  logic        BERR_IN,
  input  logic [15:0] DATA_IN,
  output logic        BR,
  output logic        BGACK,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        WR,
  output logic        DATA_OE,
  output logic [22:0] ADDR_OUT,
  output logic [2:0]  FC_OUT,
  output logic [15:0] DATA_OUT
);

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  logic bg_s, as_s, dtack_s, berr_s;

  sync2 u_sync_bg    (.clk_i(MCLK_IN), .rst_i(RESET_IN), .d_i(BG_IN),    .q_o(bg_s));
  sync2 u_sync_as    (.clk_i(MCLK_IN), .rst_i(RESET_IN), .d_i(AS_IN),    .q_o(as_s));
  sync2 u_sync_dtack (.clk_i(MCLK_IN), .rst_i(RESET_IN), .d_i(DTACK_IN), .q_o(dtack_s));
  sync2 u_sync_berr  (.clk_i(MCLK_IN), .rst_i(RESET_IN), .d_i(BERR_IN),  .q_o(berr_s));

  state_e      state_q;
  logic        wr_q, en_uds_q, en_lds_q, err_q;
  logic [22:0] addr_q;
  logic [15:0] data_q;
  logic [3:0]  setup_cnt_q;
  logic        busy_q, done_q, error_q, br_q, bgack_q, as_q, uds_q, lds_q, bus_wr_q, oe_q;
  logic [15:0] rdata_q, data_out_q;
  logic [22:0] addr_out_q;
  logic [2:0]  fc_q;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      en_uds_q    <= 1'b0;
      en_lds_q    <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      setup_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      br_q        <= 1'b0;
      bgack_q     <= 1'b0;
      as_q        <= 1'b0;
      uds_q       <= 1'b0;
      lds_q       <= 1'b0;
      bus_wr_q    <= 1'b0;
      oe_q        <= 1'b0;
      rdata_q     <= '0;
      data_out_q  <= '0;
      addr_out_q  <= '0;
      fc_q        <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (REQ_IN) begin
            if (!REQ_UDS_IN && !REQ_LDS_IN) begin
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              wr_q     <= REQ_WR_IN;
              addr_q   <= REQ_ADDR_IN;
              data_q   <= REQ_DATA_IN;
              en_uds_q <= REQ_UDS_IN;
              en_lds_q <= REQ_LDS_IN;
              err_q    <= 1'b0;
              busy_q   <= 1'b1;
              br_q     <= 1'b1;
              state_q  <= S_REQUEST;
            end
          end
        end
        S_REQUEST: begin
          // Take the bus only once the previous owner has fully let go.
          if (bg_s && !as_s && !dtack_s) begin
            br_q        <= 1'b0;
            bgack_q     <= 1'b1;
            addr_out_q  <= addr_q;
            fc_q        <= FC_SUP_DATA;
            bus_wr_q    <= wr_q;
            data_out_q  <= wr_q ? data_q : 16'h0000;
            oe_q        <= wr_q;
            setup_cnt_q <= '0;
            state_q     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (setup_cnt_q == SETUP_LAST) begin
            as_q    <= 1'b1;
            uds_q   <= en_uds_q;
            lds_q   <= en_lds_q;
`ifdef BUS_MASTER_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            state_q <= S_STROBE;
          end else begin
            setup_cnt_q <= setup_cnt_q + 4'd1;
          end
        end
        S_STROBE: begin
          if (berr_s) begin
            err_q   <= 1'b1;
            as_q    <= 1'b0;
            uds_q   <= 1'b0;
            lds_q   <= 1'b0;
            state_q <= S_RELEASE;
          end else if (dtack_s) begin
            state_q <= S_LATCH;
          end
`ifdef BUS_MASTER_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            err_q   <= 1'b1;
            as_q    <= 1'b0;
            uds_q   <= 1'b0;
            lds_q   <= 1'b0;
            state_q <= S_RELEASE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
`endif
        end
        S_LATCH: begin
          if (!wr_q) begin
            if (en_uds_q) rdata_q[15:8] <= DATA_IN[15:8];
            if (en_lds_q) rdata_q[7:0]  <= DATA_IN[7:0];
          end
          as_q    <= 1'b0;
          uds_q   <= 1'b0;
          lds_q   <= 1'b0;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          addr_out_q <= '0;
          fc_q       <= '0;
          bus_wr_q   <= 1'b0;
          data_out_q <= '0;
          oe_q       <= 1'b0;
          state_q    <= S_FINISH;
        end
        S_FINISH: begin
          // Hold the bus until the slave has withdrawn its response.
          if (!dtack_s && !berr_s) begin
            bgack_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= err_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERROR    = error_q;
  assign RDATA    = rdata_q;
  assign BR       = br_q;
  assign BGACK    = bgack_q;
  assign AS       = as_q;
  assign UDS      = uds_q;
  assign LDS      = lds_q;
  assign WR       = bus_wr_q;
  assign DATA_OE  = oe_q;
  assign ADDR_OUT = addr_out_q;
  assign FC_OUT   = fc_q;
  assign DATA_OUT = data_out_q;

endmodule

// File: tb/tb_bus_master.sv
// tb/tb_bus_master.sv - directed scoreboard bench for bus_master
module tb_bus_master;

  logic        clk = 1'b0;
  logic        RESET_IN, REQ_IN, REQ_WR_IN, REQ_UDS_IN, REQ_LDS_IN;
  logic [22:0] REQ_ADDR_IN;
  logic [15:0] REQ_DATA_IN, DATA_IN;
  logic        BG_IN, AS_IN, DTACK_IN, BERR_IN;
  logic        BUSY, DONE, ERROR, BR, BGACK, AS, UDS, LDS, WR, DATA_OE;
  logic [15:0] RDATA, DATA_OUT;
  logic [22:0] ADDR_OUT;
  logic [2:0]  FC_OUT;

  always #5 clk = ~clk;

  bus_master #(.SETUP_CYCLES(1), .TIMEOUT_CYCLES(8)) dut (
    .MCLK_IN(clk), .RESET_IN(RESET_IN), .REQ_IN(REQ_IN), .REQ_WR_IN(REQ_WR_IN),
    .REQ_ADDR_IN(REQ_ADDR_IN), .REQ_DATA_IN(REQ_DATA_IN), .REQ_UDS_IN(REQ_UDS_IN),
    .REQ_LDS_IN(REQ_LDS_IN), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .RDATA(RDATA),
    .BG_IN(BG_IN), .AS_IN(AS_IN), .DTACK_IN(DTACK_IN), .BERR_IN(BERR_IN), .DATA_IN(DATA_IN),
    .BR(BR), .BGACK(BGACK), .AS(AS), .UDS(UDS), .LDS(LDS), .WR(WR), .DATA_OE(DATA_OE),
    .ADDR_OUT(ADDR_OUT), .FC_OUT(FC_OUT), .DATA_OUT(DATA_OUT)
  );

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_rdata = 16'h0000;
  int          cnt_addr = 0, cnt_oe = 0, cnt_both = 0, cnt_uds = 0, cnt_br = 0, cnt_done = 0;

  always @(negedge clk) begin
    if (ADDR_OUT != 23'd0) cnt_addr++;
    if (DATA_OE) cnt_oe++;
    if (DATA_OE && ADDR_OUT != 23'd0) cnt_both++;
    if (UDS) cnt_uds++;
    if (BR) cnt_br++;
    if (DONE) cnt_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_addr = 0; cnt_oe = 0; cnt_both = 0; cnt_uds = 0; cnt_br = 0; cnt_done = 0;
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return BR;
      1:       return AS;
      default: return DONE;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int which, input logic val);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (pick(which) === val) ok = 1'b1;
    end
    n_cmp++;
    assert (ok) else begin
      n_bad++;
      $error("FAIL %s: timeout, observed no %b expected %b", tag, !val, val);
    end
  endtask

  task automatic finish_txn(input string tag);
    exp_t e;
    wait_sig({tag, "_done"}, 2, 1'b1);
    e = sb.pop_front();
    check({tag, "_rdata"}, RDATA, e.rdata);
    check({tag, "_error"}, ERROR, e.err);
  endtask

  task automatic issue(input logic wr, input logic [22:0] a, input logic [15:0] d,
                       input logic u, input logic l);
    REQ_WR_IN = wr; REQ_ADDR_IN = a; REQ_DATA_IN = d; REQ_UDS_IN = u; REQ_LDS_IN = l;
    REQ_IN = 1'b1;
    tick();
    REQ_IN = 1'b0;
  endtask

  task automatic run_read(input string tag, input logic [22:0] a, input logic u,
                          input logic l, input logic [15:0] bd);
    if (u) m_rdata[15:8] = bd[15:8];
    if (l) m_rdata[7:0]  = bd[7:0];
    sb.push_back({m_rdata, 1'b0});
    issue(1'b0, a, 16'h0000, u, l);
    tick(2);
    BG_IN = 1'b1;
    wait_sig({tag, "_as_on"}, 1, 1'b1);
    tick(2);
    DATA_IN = bd; DTACK_IN = 1'b1;
    wait_sig({tag, "_as_off"}, 1, 1'b0);
    DTACK_IN = 1'b0; BG_IN = 1'b0; DATA_IN = 16'h0000;
    finish_txn(tag);
  endtask

  initial begin
    RESET_IN = 1'b1; REQ_IN = 1'b0; REQ_WR_IN = 1'b0; REQ_ADDR_IN = '0; REQ_DATA_IN = '0;
    REQ_UDS_IN = 1'b0; REQ_LDS_IN = 1'b0; BG_IN = 1'b0; AS_IN = 1'b0; DTACK_IN = 1'b0;
    BERR_IN = 1'b0; DATA_IN = '0;
    tick(3);
    RESET_IN = 1'b0;
    tick();
    check("reset_ctrl", {BUSY, DONE, ERROR, BR, BGACK, AS, UDS, LDS, WR, DATA_OE}, 0);
    check("reset_bus", {ADDR_OUT, FC_OUT, DATA_OUT}, 0);
    check("reset_rdata", RDATA, 16'h0000);

    // Read 0x001000, request held high the whole time and fields perturbed after acceptance
    m_rdata = 16'hBEEF;
    sb.push_back({m_rdata, 1'b0});
    REQ_WR_IN = 1'b0; REQ_ADDR_IN = 23'h001000; REQ_UDS_IN = 1'b1; REQ_LDS_IN = 1'b1;
    REQ_IN = 1'b1;
    tick();
    check("rd_accept", {BUSY, BR}, 2'b11);
    REQ_ADDR_IN = 23'h7FFFFF; REQ_WR_IN = 1'b1;
    tick(2);
    BG_IN = 1'b1;
    wait_sig("rd_as_on", 1, 1'b1);
    check("rd_addr", ADDR_OUT, 23'h001000);
    check("rd_fc", FC_OUT, 3'b101);
    check("rd_strobes", {BR, BGACK, UDS, LDS, WR, DATA_OE}, 6'b011100);
    tick(2);
    DATA_IN = 16'hBEEF; DTACK_IN = 1'b1;
    wait_sig("rd_as_off", 1, 1'b0);
    DTACK_IN = 1'b0; BG_IN = 1'b0; DATA_IN = 16'h0000;
    finish_txn("rd");
    REQ_IN = 1'b0;
    tick();
    check("rd_no_requeue", {BUSY, DONE, BGACK}, 3'b000);
    check("rd_idle_addr", ADDR_OUT, 23'd0);

    // Write 0x000FFE, lower lane only
    clear_counts();
    sb.push_back({m_rdata, 1'b0});
    issue(1'b1, 23'h000FFE, 16'h1234, 1'b0, 1'b1);
    tick(2);
    BG_IN = 1'b1;
    wait_sig("wr_as_on", 1, 1'b1);
    check("wr_bus", {WR, DATA_OE, UDS, LDS}, 4'b1101);
    check("wr_data", DATA_OUT, 16'h1234);
    check("wr_addr", ADDR_OUT, 23'h000FFE);
    tick(2);
    DTACK_IN = 1'b1;
    wait_sig("wr_as_off", 1, 1'b0);
    DTACK_IN = 1'b0; BG_IN = 1'b0;
    finish_txn("wr");
    check("wr_uds_never", cnt_uds, 0);
    check("wr_addr_cycles", cnt_addr, 8);
    check("wr_oe_cycles", cnt_oe, 8);
    check("wr_oe_with_addr", cnt_both, 8);
    check("wr_idle_data", {DATA_OUT, 1'b0, DATA_OE}, 0);

    // Bus error together with acknowledge: error wins, no capture
    sb.push_back({m_rdata, 1'b1});
    issue(1'b0, 23'h000200, 16'h0000, 1'b1, 1'b1);
    tick(2);
    BG_IN = 1'b1;
    wait_sig("berr_as_on", 1, 1'b1);
    tick();
    DATA_IN = 16'h5555; DTACK_IN = 1'b1; BERR_IN = 1'b1;
    wait_sig("berr_as_off", 1, 1'b0);
    check("berr_release_addr", ADDR_OUT, 23'h000200);
    DTACK_IN = 1'b0; BERR_IN = 1'b0; BG_IN = 1'b0; DATA_IN = 16'h0000;
    finish_txn("berr");

    // No acknowledge: timeout build aborts, default build waits
    issue(1'b0, 23'h000400, 16'h0000, 1'b0, 1'b1);
    tick(2);
    BG_IN = 1'b1;
    wait_sig("tmo_as_on", 1, 1'b1);
`ifdef BUS_MASTER_TIMEOUT_EN
    sb.push_back({m_rdata, 1'b1});
    tick(7);
    check("tmo_as_held", AS, 1'b1);
    tick();
    check("tmo_as_dropped", AS, 1'b0);
`else
    m_rdata[7:0] = 8'h34;
    sb.push_back({m_rdata, 1'b0});
    tick(20);
    check("notmo_as_held", AS, 1'b1);
    DATA_IN = 16'h1234; DTACK_IN = 1'b1;
    wait_sig("notmo_as_off", 1, 1'b0);
    DTACK_IN = 1'b0; DATA_IN = 16'h0000;
`endif
    BG_IN = 1'b0;
    finish_txn("tmo");

    // Both byte enables clear: immediate error, no arbitration
    clear_counts();
    sb.push_back({m_rdata, 1'b1});
    issue(1'b0, 23'h000600, 16'h0000, 1'b0, 1'b0);
    check("illegal_done", DONE, 1'b1);
    begin
      exp_t e;
      e = sb.pop_front();
      check("illegal_error", ERROR, e.err);
      check("illegal_rdata", RDATA, e.rdata);
    end
    tick(3);
    check("illegal_no_br", cnt_br, 0);
    check("illegal_not_busy", BUSY, 1'b0);

    // Reset in STROBE, then a clean read
    clear_counts();
    issue(1'b0, 23'h000800, 16'h0000, 1'b1, 1'b1);
    tick(2);
    BG_IN = 1'b1;
    wait_sig("rst_as_on", 1, 1'b1);
    tick();
    RESET_IN = 1'b1;
    tick();
    check("rst_ctrl", {BUSY, DONE, ERROR, BR, BGACK, AS, UDS, LDS, WR, DATA_OE}, 0);
    check("rst_bus", {ADDR_OUT, FC_OUT, DATA_OUT}, 0);
    check("rst_rdata", RDATA, 16'h0000);
    RESET_IN = 1'b0; BG_IN = 1'b0;
    m_rdata = 16'h0000;
    tick(3);
    check("rst_no_done", cnt_done, 0);
    run_read("post_rst", 23'h000802, 1'b1, 1'b1, 16'hA5C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
